// File: rtl/motor_motion_scheduler.sv
// motor_motion_scheduler: maps line-tracker codes to ramped per-motor duty/direction with lost-line timeout and obstacle e-stop
// Ports: clk, reset (sync, active-high), enable, tracker_state[2:0], obstacle -> l/r_pwm, l/r_dir (1=fwd), l/r_duty, mode (0 IDLE,1 RUN,2 LOST,3 ESTOP)
module motor_motion_scheduler #(
  parameter int DUTY_W = 8,
  parameter logic [DUTY_W-1:0] FAST = 8'd200,
  parameter logic [DUTY_W-1:0] SLOW = 8'd120,
  parameter logic [DUTY_W-1:0] TURN = 8'd160,
  parameter int RAMP_DIV = 1000,
  parameter logic [DUTY_W-1:0] RAMP_STEP = 8'd8,
  parameter int LOST_CYC = 5_000_000,
  parameter int CLEAR_CYC = 100_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        tracker_state,
  input  logic              obstacle,
  output logic              l_pwm,
  output logic              r_pwm,
  output logic              l_dir,
  output logic              r_dir,
  output logic [DUTY_W-1:0] l_duty,
  output logic [DUTY_W-1:0] r_duty,
  output logic [1:0]        mode
);
  typedef enum logic [1:0] {IDLE, RUN, LOST, ESTOP} mode_t;
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int LW = $clog2(LOST_CYC + 1);
  localparam int CW = $clog2(CLEAR_CYC + 1);
  mode_t state, state_n;
  logic [RW-1:0] ramp_cnt;
  logic [LW-1:0] lost_cnt;
  logic [CW-1:0] clear_cnt;
  logic [DUTY_W-1:0] pwm_cnt, l_tgt, r_tgt, l_duty_n, r_duty_n;
  logic l_tdir, r_tdir, l_dir_n, r_dir_n, tick, lost_hit, clear_hit, fwdish;
  // One ramp step toward tgt, computed one bit wider so it can neither overshoot nor wrap.
  function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur, input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W:0] up, dn;
    up = {1'b0, cur} + {1'b0, RAMP_STEP};
    dn = {1'b0, cur} - {1'b0, RAMP_STEP};
    if (tgt > cur) return ({1'b0, tgt} < up) ? tgt : up[DUTY_W-1:0];
    return (dn[DUTY_W] || dn[DUTY_W-1:0] < tgt) ? tgt : dn[DUTY_W-1:0];
  endfunction
  assign tick = ramp_cnt == RW'(RAMP_DIV - 1);
  assign lost_hit = tracker_state == 3'd2 && lost_cnt == LW'(LOST_CYC - 1);
  assign clear_hit = clear_cnt == CW'(CLEAR_CYC - 1);
  assign fwdish = tracker_state inside {3'd1, 3'd3, 3'd4};
  assign mode = state;
  always_comb begin
    state_n = state;
    if (obstacle) state_n = ESTOP;
    else
      case (state)
        IDLE:    state_n = enable ? RUN : IDLE;
        RUN:     state_n = !enable ? IDLE : lost_hit ? LOST : RUN;
        LOST:    state_n = !enable ? IDLE : fwdish ? RUN : LOST;
        default: state_n = clear_hit ? (enable ? RUN : IDLE) : ESTOP;
      endcase
  end
  always_comb begin
    l_tgt = '0;
    r_tgt = '0;
    l_tdir = l_dir;
    r_tdir = r_dir;
    if (state == RUN)
      case (tracker_state)
        3'd1:    {l_tgt, l_tdir, r_tgt, r_tdir} = {FAST, 1'b1, FAST, 1'b1};
        3'd2:    {l_tgt, l_tdir, r_tgt, r_tdir} = {SLOW, 1'b0, SLOW, 1'b0};
        3'd3:    {l_tgt, l_tdir, r_tgt, r_tdir} = {SLOW, 1'b1, FAST, 1'b1};
        3'd4:    {l_tgt, l_tdir, r_tgt, r_tdir} = {FAST, 1'b1, SLOW, 1'b1};
        3'd5:    {l_tgt, l_tdir, r_tgt, r_tdir} = {TURN, 1'b0, TURN, 1'b1};
        3'd6:    {l_tgt, l_tdir, r_tgt, r_tdir} = {TURN, 1'b1, TURN, 1'b0};
        default: ;
      endcase
  end
  // A pending reversal ramps to zero first; the direction only flips on a tick that finds duty already 0.
  always_comb begin
    l_duty_n = l_duty;
    r_duty_n = r_duty;
    l_dir_n = l_dir;
    r_dir_n = r_dir;
    if (state_n == ESTOP) begin
      l_duty_n = '0;
      r_duty_n = '0;
    end else if (tick) begin
      l_duty_n = ramp(l_duty, l_tdir == l_dir ? l_tgt : '0);
      r_duty_n = ramp(r_duty, r_tdir == r_dir ? r_tgt : '0);
      l_dir_n = l_duty == '0 ? l_tdir : l_dir;
      r_dir_n = r_duty == '0 ? r_tdir : r_dir;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ramp_cnt <= '0;
      lost_cnt <= '0;
      clear_cnt <= '0;
      pwm_cnt <= '0;
      l_duty <= '0;
      r_duty <= '0;
      l_dir <= 1'b1;
      r_dir <= 1'b1;
      l_pwm <= 1'b0;
      r_pwm <= 1'b0;
    end else begin
      state <= state_n;
      ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
      lost_cnt <= (state == RUN && tracker_state == 3'd2) ? (lost_cnt == LW'(LOST_CYC - 1) ? lost_cnt : lost_cnt + 1'b1) : '0;
      clear_cnt <= (state == ESTOP && state_n == ESTOP && !obstacle) ? clear_cnt + 1'b1 : '0;
      pwm_cnt <= pwm_cnt + 1'b1;
      l_duty <= l_duty_n;
      r_duty <= r_duty_n;
      l_dir <= l_dir_n;
      r_dir <= r_dir_n;
      l_pwm <= pwm_cnt < l_duty_n;
      r_pwm <= pwm_cnt < r_duty_n;
    end
  end
endmodule

// File: tb/tb_motor_motion_scheduler.sv
// tb_motor_motion_scheduler: directed vector table, PWM counts, reset corner and random stimulus against a behavioural model
module tb_motor_motion_scheduler;
  localparam int DIV = 4, STEP = 8, LOST = 20, CLEAR = 10;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, obstacle = 1'b0;
  logic [2:0] tracker_state = 3'd0;
  logic l_pwm, r_pwm, l_dir, r_dir;
  logic [7:0] l_duty, r_duty;
  logic [1:0] mode;
  int n_chk = 0, n_fail = 0;
  motor_motion_scheduler #(.RAMP_DIV(DIV), .RAMP_STEP(8'd8), .LOST_CYC(LOST), .CLEAR_CYC(CLEAR)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tracker_state(tracker_state), .obstacle(obstacle),
    .l_pwm(l_pwm), .r_pwm(r_pwm), .l_dir(l_dir), .r_dir(r_dir), .l_duty(l_duty), .r_duty(r_duty), .mode(mode)
  );
  always #5 clk = ~clk;
  int tgt_l[8] = '{0, 200, 120, 120, 200, 160, 160, 0};
  int dir_l[8] = '{-1, 1, 0, 1, 1, 0, 1, -1};
  int tgt_r[8] = '{0, 200, 120, 200, 120, 160, 160, 0};
  int dir_r[8] = '{-1, 1, 0, 1, 1, 1, 0, -1};
  int m_mode = 0, m_ld = 0, m_rd = 0, m_ldir = 1, m_rdir = 1, m_rcnt = 0, m_pcnt = 0;
  int m_lost = 0, m_clear = 0, m_lp = 0, m_rp = 0, m_nm = 0, m_t = 0;
  bit m_tick;
  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return (tgt - cur > STEP) ? cur + STEP : tgt;
    return (cur - tgt > STEP) ? cur - STEP : tgt;
  endfunction
  function automatic void motor(inout int d, inout int dir, input int tgt, input int tdr, input bit run);
    int want_dir = (run && tdr >= 0) ? tdr : dir;
    int want = run ? tgt : 0;
    if (want_dir != dir) begin
      if (d == 0) dir = want_dir;
      else d = toward(d, 0);
    end else d = toward(d, want);
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_ld = 0; m_rd = 0; m_ldir = 1; m_rdir = 1; m_rcnt = 0; m_pcnt = 0;
      m_lost = 0; m_clear = 0; m_lp = 0; m_rp = 0;
    end else begin
      m_t = int'(tracker_state);
      m_nm = m_mode;
      if (obstacle) m_nm = 3;
      else if (m_mode == 3) begin
        if (m_clear == CLEAR - 1) m_nm = enable ? 1 : 0;
      end else if (!enable) m_nm = 0;
      else if (m_mode == 0) m_nm = 1;
      else if (m_mode == 1 && m_t == 2 && m_lost == LOST - 1) m_nm = 2;
      else if (m_mode == 2 && (m_t == 1 || m_t == 3 || m_t == 4)) m_nm = 1;
      m_lost = (m_mode == 1 && m_t == 2) ? ((m_lost < LOST - 1) ? m_lost + 1 : m_lost) : 0;
      m_clear = (m_mode == 3 && m_nm == 3 && !obstacle) ? m_clear + 1 : 0;
      m_tick = (m_rcnt == DIV - 1);
      m_rcnt = m_tick ? 0 : m_rcnt + 1;
      if (m_nm == 3) begin
        m_ld = 0;
        m_rd = 0;
      end else if (m_tick) begin
        motor(m_ld, m_ldir, tgt_l[m_t], dir_l[m_t], m_mode == 1);
        motor(m_rd, m_rdir, tgt_r[m_t], dir_r[m_t], m_mode == 1);
      end
      m_lp = (m_pcnt < m_ld) ? 1 : 0;
      m_rp = (m_pcnt < m_rd) ? 1 : 0;
      m_pcnt = (m_pcnt + 1) % 256;
      m_mode = m_nm;
    end
  end
  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    n_chk++;
    if (mode !== 2'(m_mode) || l_duty !== 8'(m_ld) || r_duty !== 8'(m_rd) || l_dir !== 1'(m_ldir) ||
        r_dir !== 1'(m_rdir) || l_pwm !== 1'(m_lp) || r_pwm !== 1'(m_rp)) begin
      n_fail++;
      $display("FAIL model @%0t: got mode=%0d l=%0d/%b r=%0d/%b pwm=%b%b, expected mode=%0d l=%0d/%0d r=%0d/%0d pwm=%0d%0d",
               $time, mode, l_duty, l_dir, r_duty, r_dir, l_pwm, r_pwm, m_mode, m_ld, m_ldir, m_rd, m_rdir, m_lp, m_rp);
    end
  endtask
  task automatic pwm_count(input int exp_l, input int exp_r);
    int lc = 0, rc = 0;
    repeat (256) begin
      cyc();
      lc += int'(l_pwm);
      rc += int'(r_pwm);
    end
    check("pwm l high count", lc, exp_l);
    check("pwm r high count", rc, exp_r);
  endtask
  typedef struct {int en, trk, obs, n, md, ld, rd, ldr, rdr;} vec_t;
  vec_t vt[25];
  int hold = 0, obs_hold = 0;
  initial begin
    vt[0]  = '{1, 1, 0, 1,   1, 0,   0,   1, 1};
    vt[1]  = '{1, 1, 0, 3,   1, 8,   8,   1, 1};
    vt[2]  = '{1, 1, 0, 4,   1, 16,  16,  1, 1};
    vt[3]  = '{1, 1, 0, 92,  1, 200, 200, 1, 1};
    vt[4]  = '{1, 1, 0, 8,   1, 200, 200, 1, 1};
    vt[5]  = '{1, 5, 0, 4,   1, 192, 192, 1, 1};
    vt[6]  = '{1, 5, 0, 16,  1, 160, 160, 1, 1};
    vt[7]  = '{1, 5, 0, 80,  1, 0,   160, 1, 1};
    vt[8]  = '{1, 5, 0, 4,   1, 0,   160, 0, 1};
    vt[9]  = '{1, 5, 0, 4,   1, 8,   160, 0, 1};
    vt[10] = '{1, 5, 0, 76,  1, 160, 160, 0, 1};
    vt[11] = '{1, 2, 0, 19,  1, 128, 128, 0, 1};
    vt[12] = '{1, 2, 0, 1,   2, 120, 120, 0, 1};
    vt[13] = '{1, 2, 0, 60,  2, 0,   0,   0, 1};
    vt[14] = '{1, 3, 0, 1,   1, 0,   0,   0, 1};
    vt[15] = '{1, 3, 0, 3,   1, 0,   8,   1, 1};
    vt[16] = '{1, 3, 0, 100, 1, 120, 200, 1, 1};
    vt[17] = '{1, 3, 1, 1,   3, 0,   0,   1, 1};
    vt[18] = '{1, 3, 0, 9,   3, 0,   0,   1, 1};
    vt[19] = '{1, 3, 1, 1,   3, 0,   0,   1, 1};
    vt[20] = '{1, 3, 0, 9,   3, 0,   0,   1, 1};
    vt[21] = '{1, 3, 0, 1,   1, 0,   0,   1, 1};
    vt[22] = '{1, 3, 0, 120, 1, 120, 200, 1, 1};
    vt[23] = '{1, 0, 0, 120, 1, 0,   0,   1, 1};
    vt[24] = '{1, 6, 0, 12,  1, 24,  16,  1, 0};
    repeat (3) cyc();
    check("reset mode", int'(mode), 0);
    check("reset l_duty", int'(l_duty), 0);
    check("reset r_duty", int'(r_duty), 0);
    check("reset dirs", int'({l_dir, r_dir}), 3);
    check("reset pwm", int'({l_pwm, r_pwm}), 0);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      enable = vt[i].en != 0;
      tracker_state = 3'(vt[i].trk);
      obstacle = vt[i].obs != 0;
      repeat (vt[i].n) cyc();
      check($sformatf("row%0d mode", i), int'(mode), vt[i].md);
      check($sformatf("row%0d l_duty", i), int'(l_duty), vt[i].ld);
      check($sformatf("row%0d r_duty", i), int'(r_duty), vt[i].rd);
      check($sformatf("row%0d l_dir", i), int'(l_dir), vt[i].ldr);
      check($sformatf("row%0d r_dir", i), int'(r_dir), vt[i].rdr);
      if (i == 17) check("estop entry pwm", int'({l_pwm, r_pwm}), 0);
      if (i == 22) pwm_count(120, 200);
      if (i == 23) pwm_count(0, 0);
    end
    reset = 1'b1;
    obstacle = 1'b1;
    cyc();
    check("mid-ramp reset mode", int'(mode), 0);
    check("mid-ramp reset duties", int'({l_duty, r_duty}), 0);
    check("mid-ramp reset dirs", int'({l_dir, r_dir}), 3);
    check("mid-ramp reset pwm", int'({l_pwm, r_pwm}), 0);
    reset = 1'b0;
    obstacle = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        tracker_state = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 30);
      end else hold--;
      if (enable ? $urandom_range(0, 299) == 0 : $urandom_range(0, 19) == 0) enable = ~enable;
      if (obs_hold > 0) begin
        obstacle = 1'b1;
        obs_hold--;
      end else begin
        obstacle = ($urandom_range(0, 249) == 0) || (m_mode == 3 && $urandom_range(0, 11) == 0);
        if ($urandom_range(0, 399) == 0) obs_hold = $urandom_range(1, 5);
      end
      reset = $urandom_range(0, 1499) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
